// File: rtl/frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : frame_capture
// Description : Captures one raster-order frame of IMAGE_WIDTH x IMAGE_HEIGHT
//               pixels into internal storage, then streams it back out with
//               a valid/ready handshake and line/frame markers. A stored frame
//               may be read out any number of times until a new capture.
// Ports       : clk               - single clock, rising edge
//               resetn            - asynchronous active-low reset
//               start             - pulse, arms a capture (IDLE or FULL)
//               input_data        - incoming pixel
//               input_data_valid  - input_data qualifier
//               readout_start     - pulse, streams the stored frame (FULL)
//               output_ready      - downstream accepts output this cycle
//               output_data       - stored pixel, raster order
//               output_data_valid - output_data qualifier
//               output_eol        - last pixel of a line
//               output_eof        - last pixel of the frame
//               frame_done        - a complete frame is held
//               overflow          - sticky, pixel arrived while not capturing
//               busy              - capturing or reading out
// Revision    : 1.0 - initial release
// ============================================================================
module frame_capture #(
   parameter int PX_SIZE      = 8,
   parameter int IMAGE_WIDTH  = 64,
   parameter int IMAGE_HEIGHT = 64
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [PX_SIZE-1:0] input_data,
   input  logic               input_data_valid,
   input  logic               readout_start,
   input  logic               output_ready,
   output logic [PX_SIZE-1:0] output_data,
   output logic               output_data_valid,
   output logic               output_eol,
   output logic               output_eof,
   output logic               frame_done,
   output logic               overflow,
   output logic               busy
);

   localparam int c_depth = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int c_aw    = (c_depth > 1) ? $clog2(c_depth) : 1;
   // Read counter needs one extra code to mark "all pixels issued".
   localparam int c_cw    = $clog2(c_depth + 1);

   localparam logic [11:0]     c_col_last  = 12'(IMAGE_WIDTH - 1);
   localparam logic [11:0]     c_line_last = 12'(IMAGE_HEIGHT - 1);
   localparam logic [c_cw-1:0] c_rd_end    = c_cw'(c_depth);
   localparam logic [c_cw-1:0] c_rd_last   = c_cw'(c_depth - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_FULL    = 2'd2,
      ST_READOUT = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [PX_SIZE-1:0] r_mem [0:c_depth-1];

   logic [11:0]        r_col;
   logic [11:0]        r_line;
   logic [c_aw-1:0]    r_wr_addr;
   logic [c_cw-1:0]    r_rd_cnt;
   logic [11:0]        r_rd_col;
   logic [PX_SIZE-1:0] r_out_data;
   logic               r_out_valid;
   logic               r_out_eol;
   logic               r_out_eof;
   logic               r_overflow;

   logic w_start_ok;
   logic w_wr_en;
   logic w_last_px;
   logic w_ro_go;
   logic w_advance;
   logic w_issue;
   logic w_eof_xfer;

   // ------------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_FULL));
      w_wr_en     = (r_state == ST_CAPTURE) && input_data_valid;
      w_last_px   = w_wr_en && (r_col == c_col_last) && (r_line == c_line_last);
      // start has priority over readout_start in FULL.
      w_ro_go     = (r_state == ST_FULL) && readout_start && !start;
      // The output register may load whenever it is empty or being drained.
      w_advance   = !r_out_valid || output_ready;
      w_issue     = (r_state == ST_READOUT) && w_advance && (r_rd_cnt != c_rd_end);
      w_eof_xfer  = r_out_valid && r_out_eof && output_ready;
      w_state_nxt = r_state;

      case (r_state)
         ST_IDLE:    if (w_start_ok) w_state_nxt = ST_CAPTURE;
         ST_CAPTURE: if (w_last_px)  w_state_nxt = ST_FULL;
         ST_FULL: begin
            if (w_start_ok)   w_state_nxt = ST_CAPTURE;
            else if (w_ro_go) w_state_nxt = ST_READOUT;
         end
         ST_READOUT: if (w_eof_xfer) w_state_nxt = ST_FULL;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Frame storage (no reset: contents are undefined after reset)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_addr] <= input_data;
   end

   // ------------------------------------------------------------------------
   // State, counters and output stage
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_col       <= '0;
         r_line      <= '0;
         r_wr_addr   <= '0;
         r_rd_cnt    <= '0;
         r_rd_col    <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_eol   <= 1'b0;
         r_out_eof   <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         // Capture position; the linear write address tracks line*W+col.
         if (w_start_ok) begin
            r_col     <= '0;
            r_line    <= '0;
            r_wr_addr <= '0;
         end else if (w_wr_en) begin
            r_wr_addr <= r_wr_addr + c_aw'(1);
            if (r_col == c_col_last) begin
               r_col  <= '0;
               r_line <= r_line + 12'd1;
            end else begin
               r_col  <= r_col + 12'd1;
            end
         end

         // A dropped pixel in the same cycle as start still flags overflow.
         if (input_data_valid && (r_state != ST_CAPTURE)) r_overflow <= 1'b1;
         else if (w_start_ok)                             r_overflow <= 1'b0;

         if (w_ro_go) begin
            r_rd_cnt <= '0;
            r_rd_col <= '0;
         end else if (w_issue) begin
            r_rd_cnt <= r_rd_cnt + c_cw'(1);
            r_rd_col <= (r_rd_col == c_col_last) ? 12'd0 : r_rd_col + 12'd1;
         end

         // Synchronous-read output register: holds while stalled, refills
         // every cycle while drained so the stream has no bubbles.
         if ((r_state == ST_READOUT) && w_advance) begin
            r_out_valid <= w_issue;
            if (w_issue) begin
               r_out_data <= r_mem[r_rd_cnt[c_aw-1:0]];
               r_out_eol  <= (r_rd_col == c_col_last);
               r_out_eof  <= (r_rd_cnt == c_rd_last);
            end else begin
               r_out_eol  <= 1'b0;
               r_out_eof  <= 1'b0;
            end
         end
      end
   end

   assign output_data       = r_out_data;
   assign output_data_valid = r_out_valid;
   assign output_eol        = r_out_eol;
   assign output_eof        = r_out_eof;
   assign overflow          = r_overflow;
   assign frame_done        = (r_state == ST_FULL);
   assign busy              = (r_state == ST_CAPTURE) || (r_state == ST_READOUT);

endmodule
`default_nettype wire

// File: tb/tb_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_capture
// Description : Self-checking bench for frame_capture on a 4x4 frame. Keeps
//               the expected frame as a plain array and derives eol/eof from
//               the pixel index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_capture;

   localparam int PX = 8;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int N  = W * H;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic [PX-1:0] input_data;
   logic          input_data_valid;
   logic          readout_start;
   logic          output_ready;
   logic [PX-1:0] output_data;
   logic          output_data_valid;
   logic          output_eol;
   logic          output_eof;
   logic          frame_done;
   logic          overflow;
   logic          busy;

   logic [PX-1:0] fr [N];
   int            n_cmp = 0;
   int            n_err = 0;

   frame_capture #(
      .PX_SIZE      (PX),
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H)
   ) dut (
      .clk               (clk),
      .resetn            (resetn),
      .start             (start),
      .input_data        (input_data),
      .input_data_valid  (input_data_valid),
      .readout_start     (readout_start),
      .output_ready      (output_ready),
      .output_data       (output_data),
      .output_data_valid (output_data_valid),
      .output_eol        (output_eol),
      .output_eof        (output_eof),
      .frame_done        (frame_done),
      .overflow          (overflow),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: back-to-back, 1: valid toggling 1,0,1,0, 2: random gaps with
   // ignored start/readout_start pulses inside the gaps.
   task automatic do_capture(input int mode, input bit seq, input bit issue_start);
      if (issue_start) begin
         start = 1'b1;
         step();
         start = 1'b0;
         chk("cap_busy", busy, 1);
         chk("cap_ovf_clr", overflow, 0);
         chk("cap_fd_low", frame_done, 0);
      end
      for (int k = 0; k < N; k++) begin
         int gaps;
         logic [PX-1:0] px;
         gaps = (mode == 0) ? 0 : (mode == 1) ? ((k > 0) ? 1 : 0) : int'($urandom_range(0, 3));
         input_data_valid = 1'b0;
         for (int g = 0; g < gaps; g++) begin
            input_data = PX'($urandom);
            if (mode == 2) begin
               start         = 1'($urandom_range(0, 1));
               readout_start = 1'($urandom_range(0, 1));
            end
            step();
         end
         start         = 1'b0;
         readout_start = 1'b0;
         px = seq ? PX'(k) : PX'($urandom);
         fr[k] = px;
         input_data       = px;
         input_data_valid = 1'b1;
         step();
         chk("cap_frame_done", frame_done, (k == N - 1) ? 1 : 0);
      end
      input_data_valid = 1'b0;
      chk("cap_busy_end", busy, 0);
   endtask

   // mode 0: ready=1, 1: ready pattern 1,0,0,1, 2: random ready.
   // abort_at >= 0 leaves the task with pixel abort_at on the bus.
   task automatic do_readout(input int mode, input int abort_at);
      int            idx = 0;
      int            cyc = 0;
      int            first = -1;
      int            last = -1;
      bit            stalled = 0;
      bit            r;
      logic [PX-1:0] hd = '0;
      logic          he = 1'b0;
      logic          hf = 1'b0;
      readout_start = 1'b1;
      step();
      readout_start = 1'b0;
      chk("ro_busy", busy, 1);
      while (idx < N && idx != abort_at && cyc < 300) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         output_ready = r;
         if (stalled) begin
            chk("hold_valid", output_data_valid, 1);
            chk("hold_data", output_data, hd);
            chk("hold_eol", output_eol, he);
            chk("hold_eof", output_eof, hf);
         end
         if (output_data_valid) begin
            if (first < 0) first = cyc;
            if (r) begin
               chk("ro_data", output_data, fr[idx]);
               chk("ro_eol", output_eol, ((idx % W) == W - 1) ? 1 : 0);
               chk("ro_eof", output_eof, (idx == N - 1) ? 1 : 0);
               last = cyc;
               idx++;
            end
            stalled = !r;
            hd = output_data;
            he = output_eol;
            hf = output_eof;
         end else begin
            stalled = 0;
         end
         if (idx < N && idx != abort_at) begin
            step();
            cyc++;
         end else if (idx == N) begin
            step();
         end
      end
      output_ready = 1'b0;
      chk("ro_first_latency", (first >= 0 && first <= 1) ? 1 : 0, 1);
      if (abort_at < 0) begin
         chk("ro_count", idx, N);
         if (mode == 0) chk("ro_no_gaps", last - first, N - 1);
         chk("ro_end_valid", output_data_valid, 0);
         chk("ro_end_fd", frame_done, 1);
         chk("ro_end_busy", busy, 0);
      end else begin
         chk("ro_abort_idx", idx, abort_at);
      end
   endtask

   initial begin
      resetn           = 1'b0;
      start            = 1'b0;
      input_data       = '0;
      input_data_valid = 1'b0;
      readout_start    = 1'b0;
      output_ready     = 1'b0;

      // Reset state, before any clock edge.
      #3;
      chk("rst_valid", output_data_valid, 0);
      chk("rst_data", output_data, 0);
      chk("rst_eol", output_eol, 0);
      chk("rst_eof", output_eof, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
      step();
      step();
      resetn = 1'b1;

      // Pixel in IDLE sets overflow; readout_start in IDLE ignored.
      input_data       = 8'hA5;
      input_data_valid = 1'b1;
      step();
      input_data_valid = 1'b0;
      chk("idle_ovf", overflow, 1);
      readout_start = 1'b1;
      step();
      readout_start = 1'b0;
      chk("idle_ovf_sticky", overflow, 1);
      chk("idle_ro_busy", busy, 0);
      step();
      chk("idle_ro_valid", output_data_valid, 0);

      // Back-to-back 0..15, readout with ready held high.
      do_capture(0, 1, 1);
      do_readout(0, -1);

      // Toggling valid gives the same frame and readout.
      do_capture(1, 1, 1);
      do_readout(0, -1);

      // Random data with gaps; stalled readouts, read twice.
      do_capture(2, 0, 1);
      do_readout(1, -1);
      do_readout(2, -1);

      // Pixel in FULL: overflow sticky, storage untouched.
      input_data       = PX'($urandom);
      input_data_valid = 1'b1;
      step();
      input_data_valid = 1'b0;
      chk("full_ovf", overflow, 1);
      repeat (3) step();
      chk("full_ovf_sticky", overflow, 1);
      chk("full_fd", frame_done, 1);
      do_readout(0, -1);
      chk("ro_ovf_sticky", overflow, 1);

      // start and readout_start together in FULL: start wins.
      start         = 1'b1;
      readout_start = 1'b1;
      step();
      start         = 1'b0;
      readout_start = 1'b0;
      chk("both_busy", busy, 1);
      chk("both_fd", frame_done, 0);
      chk("both_ovf_clr", overflow, 0);
      for (int i = 0; i < 3; i++) begin
         chk("both_no_valid", output_data_valid, 0);
         step();
      end
      do_capture(2, 0, 0);
      do_readout(0, -1);

      // Asynchronous reset in the middle of readout, at pixel 6.
      do_readout(2, 6);
      resetn = 1'b0;
      #1;
      chk("arst_valid", output_data_valid, 0);
      chk("arst_data", output_data, 0);
      chk("arst_eol", output_eol, 0);
      chk("arst_eof", output_eof, 0);
      chk("arst_fd", frame_done, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_busy", busy, 0);
      step();
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         readout_start = 1'b1;
         step();
         readout_start = 1'b0;
         chk("post_rst_busy", busy, 0);
         chk("post_rst_valid", output_data_valid, 0);
      end

      // Start acted on at the first edge after reset release.
      resetn = 1'b0;
      #1;
      resetn = 1'b1;
      do_capture(2, 0, 1);
      do_readout(2, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter PX_SIZE, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 64, pixels per line.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 64, lines per frame.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse; arms a new capture.
REQ-007 SHALL have port input_data  in  PX_SIZE  incoming pixel, raster order.
REQ-008 SHALL have port input_data_valid  in  1  input_data is valid this cycle.
REQ-009 SHALL have port readout_start  in  1  one-cycle pulse; begins streaming the stored frame.
REQ-010 SHALL have port output_ready  in  1  downstream accepts output this cycle.
REQ-011 SHALL have port output_data  out  PX_SIZE  stored pixel, raster order.
REQ-012 SHALL have port output_data_valid  out  1  output_data is valid.
REQ-013 SHALL have port output_eol  out  1  qualifies the last pixel of a line.
REQ-014 SHALL have port output_eof  out  1  qualifies the last pixel of the frame.
REQ-015 SHALL have port frame_done  out  1  high while a complete frame is held (state FULL).
REQ-016 SHALL have port overflow  out  1  sticky; a valid pixel arrived while not capturing.
REQ-017 SHALL have port busy  out  1  high in CAPTURE or READOUT.

Function
REQ-018 SHALL implement states IDLE, CAPTURE, FULL, READOUT.
REQ-019 Transitions SHALL be:
- IDLE->CAPTURE on start.
- CAPTURE->FULL when pixel IMAGE_WIDTH*IMAGE_HEIGHT is accepted.
- FULL->READOUT on readout_start.
- READOUT->FULL after the eof pixel is accepted.
- FULL->CAPTURE on start; the previous frame is discarded.
REQ-020 Internal storage SHALL hold IMAGE_WIDTH*IMAGE_HEIGHT words of PX_SIZE bits.
REQ-021 In CAPTURE, each cycle with input_data_valid=1 SHALL write input_data at address line*IMAGE_WIDTH+col.
REQ-022 Capture counters col and line SHALL each be 12 bits wide.
- col SHALL wrap from IMAGE_WIDTH-1 to 0 and increment line.
- Both SHALL clear on entering CAPTURE.
REQ-023 Cycles with input_data_valid=0 in CAPTURE SHALL advance nothing; gaps of any length are legal.
REQ-024 input_data_valid=1 in IDLE, FULL or READOUT SHALL drop the pixel and set overflow; storage is unchanged.
REQ-025 overflow SHALL clear only on start or reset.
REQ-026 start in CAPTURE or READOUT SHALL be ignored.
REQ-027 readout_start outside FULL SHALL be ignored.
REQ-028 start and readout_start asserted together in FULL SHALL resolve in favour of start.
REQ-029 frame_done SHALL rise the cycle after the last pixel is written.
REQ-030 In READOUT, the first output_data_valid SHALL appear no later than 2 cycles after readout_start (memory read latency 1).
REQ-031 Output handshake: a pixel transfers when output_data_valid=1 and output_ready=1.
REQ-032 While output_data_valid=1 and output_ready=0, output_data, output_eol and output_eof SHALL hold stable.
REQ-033 With output_ready held at 1, READOUT SHALL sustain one pixel per cycle with no bubbles after the first.
REQ-034 output_eol SHALL be 1 exactly on pixels with column IMAGE_WIDTH-1.
REQ-035 output_eof SHALL be 1 only on the final pixel; output_eol is also 1 on that pixel.
REQ-036 Readout SHALL NOT modify storage; a frame may be read out any number of times.

Reset
REQ-037 resetn=0 SHALL immediately, without clk, force:
- state IDLE, counters 0;
- output_data_valid, output_eol, output_eof, frame_done, overflow, busy all 0;
- output_data 0.
REQ-038 Reset mid-CAPTURE or mid-READOUT SHALL abandon the operation; storage contents are undefined after reset.
REQ-039 After resetn deasserts, the block SHALL act on start at the first rising edge.

Verification
REQ-040 IMAGE_WIDTH=4, IMAGE_HEIGHT=4: start, feed 0..15 back-to-back, then readout_start with output_ready=1 -> frame_done high the cycle after pixel 15; output 0..15 with no gaps; eol on 3,7,11,15; eof on 15 only.
REQ-041 Capture with input_data_valid toggling 1,0,1,0 -> same stored frame and same readout as the back-to-back case.
REQ-042 Readout with output_ready pattern 1,0,0,1 repeating -> every pixel delivered exactly once, in order, held stable while stalled.
REQ-043 Valid pixel in IDLE and again in FULL -> overflow=1 and stays 1; readout unchanged; next start clears overflow.
REQ-044 resetn pulsed low during readout at pixel 6 -> all outputs 0 asynchronously, state IDLE; readout_start ignored until a new capture completes.
REQ-045 start and readout_start in the same cycle in FULL -> enters CAPTURE; no output_data_valid asserted.
